// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM array: command mode encodings and
// default timing constants for a 27 MHz clock driving 20 ms servo frames.
package servo_pkg;

  typedef enum logic [1:0] {
    MODE_ABS    = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_CENTER = 2'b11
  } cmd_mode_e;

  localparam int DEF_PERIOD_COUNT = 540000;
  localparam int DEF_MIN_PULSE    = 13500;
  localparam int DEF_MAX_PULSE    = 67500;
  localparam int DEF_CENTER       = 40500;
  localparam int DEF_SLEW_STEP    = 2700;

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: holds the commanded target and the active pulse width.
// Commands update the target immediately (saturated to the legal range);
// the pulse only creeps toward the target by at most SLEW_STEP once per frame.
module servo_slew_channel
  import servo_pkg::*;
#(
  parameter int PULSE_W   = 17,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int MAX_PULSE = DEF_MAX_PULSE,
  parameter int CENTER    = DEF_CENTER,
  parameter int SLEW_STEP = DEF_SLEW_STEP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_we_i,
  input  logic [1:0]         cmd_mode_i,
  input  logic [PULSE_W-1:0] cmd_val_i,
  input  logic               slew_en_i,
  output logic [PULSE_W-1:0] target_o,
  output logic [PULSE_W-1:0] pulse_o
);

  localparam logic [PULSE_W:0]   MIN_EXT    = (PULSE_W+1)'(MIN_PULSE);
  localparam logic [PULSE_W:0]   MAX_EXT    = (PULSE_W+1)'(MAX_PULSE);
  localparam logic [PULSE_W:0]   CENTER_EXT = (PULSE_W+1)'(CENTER);
  localparam logic [PULSE_W-1:0] CENTER_P   = PULSE_W'(CENTER);
  localparam logic [PULSE_W-1:0] STEP       = PULSE_W'(SLEW_STEP);

  logic [PULSE_W-1:0] target_q, target_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic [PULSE_W:0]   targetExt, valExt, sum, diff, rawNext, targetSat;
  logic [PULSE_W-1:0] gap;

  // Next target: one extra bit of headroom so up/down never wrap, then clamp.
  always_comb begin
    targetExt = {1'b0, target_q};
    valExt    = {1'b0, cmd_val_i};
    sum       = targetExt + valExt;
    diff      = targetExt - valExt;
    rawNext   = targetExt;
    case (cmd_mode_e'(cmd_mode_i))
      MODE_ABS:    rawNext = valExt;
      MODE_UP:     rawNext = sum;
      MODE_DOWN:   rawNext = diff[PULSE_W] ? MIN_EXT : diff;
      MODE_CENTER: rawNext = CENTER_EXT;
      default:     rawNext = targetExt;
    endcase
    if (rawNext < MIN_EXT) begin
      targetSat = MIN_EXT;
    end else if (rawNext > MAX_EXT) begin
      targetSat = MAX_EXT;
    end else begin
      targetSat = rawNext;
    end
    target_d = cmd_we_i ? PULSE_W'(targetSat) : target_q;
  end

  // Next pulse: at the frame boundary step toward the pre-edge target, capped at STEP.
  always_comb begin
    pulse_d = pulse_q;
    gap     = '0;
    if (slew_en_i) begin
      if (target_q > pulse_q) begin
        gap     = target_q - pulse_q;
        pulse_d = (gap > STEP) ? pulse_q + STEP : target_q;
      end else if (target_q < pulse_q) begin
        gap     = pulse_q - target_q;
        pulse_d = (gap > STEP) ? pulse_q - STEP : target_q;
      end
    end
  end

  // Target and pulse registers, both parked at centre on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      target_q <= CENTER_P;
      pulse_q  <= CENTER_P;
    end else begin
      target_q <= target_d;
      pulse_q  <= pulse_d;
    end
  end

  assign target_o = target_q;
  assign pulse_o  = pulse_q;

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo PWM generator. Owns the shared frame counter,
// decodes commands into per-channel writes, and compares the counter with
// each channel's pulse width to drive registered PWM outputs.
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CH_W         = 1,
  parameter int COUNT_W      = 20,
  parameter int PULSE_W      = 17,
  parameter int PERIOD_COUNT = DEF_PERIOD_COUNT,
  parameter int MIN_PULSE    = DEF_MIN_PULSE,
  parameter int MAX_PULSE    = DEF_MAX_PULSE,
  parameter int CENTER       = DEF_CENTER,
  parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CH_W-1:0]           cmd_ch,
  input  logic [1:0]                cmd_mode,
  input  logic [PULSE_W-1:0]        cmd_val,
  output logic                      cmd_err,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic                      frame_start,
  output logic [NUM_CH*PULSE_W-1:0] pulse_width,
  output logic [NUM_CH*PULSE_W-1:0] target_width
);

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(PERIOD_COUNT - 1);

  logic [COUNT_W-1:0] count_q, count_d;
  logic [NUM_CH-1:0]  pwm_q, pwm_d;
  logic               cmd_err_q, cmd_err_d;
  logic               frameEnd;
  logic               cmdAccept;
  logic               chValid;

  // The block never stalls commands; it is only unready while held in reset.
  assign cmd_ready   = ~reset;
  assign cmdAccept   = cmd_valid & cmd_ready;
  assign chValid     = 32'(cmd_ch) < 32'(NUM_CH);
  assign frameEnd    = (count_q == LAST_COUNT);
  assign frame_start = ~reset & (count_q == '0);

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    logic chWe;
    assign chWe = cmdAccept & chValid & (cmd_ch == CH_W'(c));

    servo_slew_channel #(
      .PULSE_W  (PULSE_W),
      .MIN_PULSE(MIN_PULSE),
      .MAX_PULSE(MAX_PULSE),
      .CENTER   (CENTER),
      .SLEW_STEP(SLEW_STEP)
    ) uChannel (
      .clock     (clock),
      .reset     (reset),
      .cmd_we_i  (chWe),
      .cmd_mode_i(cmd_mode),
      .cmd_val_i (cmd_val),
      .slew_en_i (frameEnd),
      .target_o  (target_width[c*PULSE_W +: PULSE_W]),
      .pulse_o   (pulse_width[c*PULSE_W +: PULSE_W])
    );
  end

  // Next-state for the frame counter, PWM comparators and the reject strobe.
  always_comb begin
    count_d   = frameEnd ? '0 : count_q + COUNT_W'(1);
    cmd_err_d = cmdAccept & ~chValid;
    pwm_d     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pwm_d[c] = 32'(count_q) < 32'(pulse_width[c*PULSE_W +: PULSE_W]);
    end
  end

  // Counter, PWM lines and error strobe; reset drops every drive line at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      pwm_q     <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pwm_q     <= pwm_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign pwm_out = pwm_q;
  assign cmd_err = cmd_err_q;

endmodule
